pipeline_hazard_controller: RTL and testbench

Sequences the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). The pipeline has no forwarding, and branches/jumps resolve in WB.
- Tracks in-flight destination registers in a 3-entry scoreboard.
- Stalls IF/ID and injects ID/EX bubbles on RAW hazards.
- Flushes younger stages on a taken redirect.
- Optionally holds fetch behind control instructions until they resolve.
- Drives the pipeline register enable/flush inputs and the PC register enable.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_scoreboard.sv | 45 ++++
 rtl/pipeline_hazard_controller.sv | 124 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its scoreboard.
package hazard_pkg;

  localparam logic [4:0] X0               = 5'd0;
  localparam int unsigned SB_DEPTH        = 3;
  localparam logic [1:0] CTRL_WAIT_CYCLES = 2'd2;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_entry_t;

  typedef enum logic {
    RUN       = 1'b0,
    CTRL_WAIT = 1'b1
  } state_t;

  function automatic logic entry_hit(input sb_entry_t e, input logic [4:0] r);
    return e.v && (e.rd == r);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-stage destination scoreboard (EX, MEM, WB) shadowing the in-flight writers.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned WB_BYPASS = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      advance,
  input  logic      bubble,
  input  logic      clear,
  input  sb_entry_t id_entry,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic      match_rs1,
  output logic      match_rs2
);

  // Index 0 = EX, 1 = MEM, 2 = WB.
  sb_entry_t sb_reg [SB_DEPTH];
  logic [SB_DEPTH-1:0] hit_rs1;
  logic [SB_DEPTH-1:0] hit_rs2;

  // A write-before-read register file makes the WB slot invisible to the hazard check.
  for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_stage
    localparam bit IN_WINDOW = (gi < 2) || (WB_BYPASS == 0);
    assign hit_rs1[gi] = IN_WINDOW ? entry_hit(sb_reg[gi], rs1) : 1'b0;
    assign hit_rs2[gi] = IN_WINDOW ? entry_hit(sb_reg[gi], rs2) : 1'b0;
  end

  assign match_rs1 = |hit_rs1;
  assign match_rs2 = |hit_rs2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) sb_reg[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < SB_DEPTH; i++) sb_reg[i] <= '0;
    end else if (advance || bubble) begin
      sb_reg[0] <= bubble ? sb_entry_t'('0) : id_entry;
      for (int i = 1; i < SB_DEPTH; i++) sb_reg[i] <= sb_reg[i-1];
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencing for a 5-stage pipeline without forwarding, branches resolving in WB.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned WB_BYPASS   = 1,
  parameter int unsigned CTRL_POLICY = 0,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid_i,
  input  logic [4:0]           id_rs1_i,
  input  logic [4:0]           id_rs2_i,
  input  logic                 id_use_rs1_i,
  input  logic                 id_use_rs2_i,
  input  logic [4:0]           id_rd_i,
  input  logic                 id_reg_write_i,
  input  logic                 id_is_ctrl_i,
  input  logic                 redirect_i,
  output logic                 pc_enable_o,
  output logic                 if_id_enable_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_flush_o,
  output logic                 ex_mem_flush_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic [CNT_WIDTH-1:0] flush_count_o,
  output logic                 state_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state_reg, state_next;
  logic [1:0]            wait_cnt_reg, wait_cnt_next;
  logic [CNT_WIDTH-1:0]  stall_cycles_reg, flush_count_reg;
  sb_entry_t             id_entry;
  logic                  match_rs1, match_rs2, hazard;
  logic                  sb_clear, sb_bubble;

  assign id_entry.v  = id_valid_i && id_reg_write_i && (id_rd_i != X0);
  assign id_entry.rd = id_rd_i;

  hazard_scoreboard #(.WB_BYPASS(WB_BYPASS)) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .advance   (!sb_clear && !sb_bubble),
    .bubble    (sb_bubble),
    .clear     (sb_clear),
    .id_entry  (id_entry),
    .rs1       (id_rs1_i),
    .rs2       (id_rs2_i),
    .match_rs1 (match_rs1),
    .match_rs2 (match_rs2)
  );

  assign hazard = id_valid_i &&
                  ((id_use_rs1_i && (id_rs1_i != X0) && match_rs1) ||
                   (id_use_rs2_i && (id_rs2_i != X0) && match_rs2));

  always_comb begin
    pc_enable_o    = 1'b1;
    if_id_enable_o = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    sb_clear       = 1'b0;
    sb_bubble      = 1'b0;
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;

    if (redirect_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
      sb_clear       = 1'b1;
    end else if (hazard) begin
      pc_enable_o    = 1'b0;
      if_id_enable_o = 1'b0;
      id_ex_flush_o  = 1'b1;
      sb_bubble      = 1'b1;
    end else if (state_reg == CTRL_WAIT) begin
      if (wait_cnt_reg != 2'd0) begin
        pc_enable_o   = 1'b0;
        if_id_flush_o = 1'b1;
      end
    end else if ((CTRL_POLICY != 0) && id_valid_i && id_is_ctrl_i) begin
      // The control instruction issues; the fall-through fetch behind it is dropped.
      pc_enable_o   = 1'b0;
      if_id_flush_o = 1'b1;
    end

    // The control instruction keeps moving toward WB even while a younger hazard stalls ID.
    if (redirect_i) begin
      state_next    = RUN;
      wait_cnt_next = 2'd0;
    end else if (state_reg == CTRL_WAIT) begin
      if (wait_cnt_reg != 2'd0) wait_cnt_next = wait_cnt_reg - 2'd1;
      else                      state_next    = RUN;
    end else if ((CTRL_POLICY != 0) && id_valid_i && id_is_ctrl_i && !hazard) begin
      state_next    = CTRL_WAIT;
      wait_cnt_next = CTRL_WAIT_CYCLES;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= RUN;
      wait_cnt_reg     <= 2'd0;
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (!pc_enable_o && (stall_cycles_reg != CNT_MAX))
        stall_cycles_reg <= stall_cycles_reg + CNT_WIDTH'(1);
      if (redirect_i && (flush_count_reg != CNT_MAX))
        flush_count_reg <= flush_count_reg + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles_o = stall_cycles_reg;
  assign flush_count_o  = flush_count_reg;
  assign state_o        = (state_reg == CTRL_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: three controller instances (default, WB stall, fetch-freeze) share one stimulus.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_ctrl, redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        a_pc_en, a_if_id_en, a_if_id_fl, a_id_ex_fl, a_ex_mem_fl, a_state;
  logic        b_pc_en, b_if_id_en, b_if_id_fl, b_id_ex_fl, b_ex_mem_fl, b_state;
  logic        c_pc_en, c_if_id_en, c_if_id_fl, c_id_ex_fl, c_ex_mem_fl, c_state;
  logic [31:0] a_stall, a_flush, b_stall, b_flush, c_stall, c_flush;

  // {pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush}
  logic [4:0] a_ctl, b_ctl, c_ctl;
  assign a_ctl = {a_pc_en, a_if_id_en, a_if_id_fl, a_id_ex_fl, a_ex_mem_fl};
  assign b_ctl = {b_pc_en, b_if_id_en, b_if_id_fl, b_id_ex_fl, b_ex_mem_fl};
  assign c_ctl = {c_pc_en, c_if_id_en, c_if_id_fl, c_id_ex_fl, c_ex_mem_fl};

  localparam logic [4:0] NORMAL = 5'b11000;
  localparam logic [4:0] STALL  = 5'b00010;
  localparam logic [4:0] REDIR  = 5'b11111;
  localparam logic [4:0] HOLD   = 5'b01100;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.WB_BYPASS(1), .CTRL_POLICY(0), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .reset(reset), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_is_ctrl_i(id_is_ctrl), .redirect_i(redirect),
    .pc_enable_o(a_pc_en), .if_id_enable_o(a_if_id_en), .if_id_flush_o(a_if_id_fl),
    .id_ex_flush_o(a_id_ex_fl), .ex_mem_flush_o(a_ex_mem_fl), .stall_cycles_o(a_stall),
    .flush_count_o(a_flush), .state_o(a_state));

  pipeline_hazard_controller #(.WB_BYPASS(0), .CTRL_POLICY(0), .CNT_WIDTH(32)) dut_b (
    .clk(clk), .reset(reset), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_is_ctrl_i(id_is_ctrl), .redirect_i(redirect),
    .pc_enable_o(b_pc_en), .if_id_enable_o(b_if_id_en), .if_id_flush_o(b_if_id_fl),
    .id_ex_flush_o(b_id_ex_fl), .ex_mem_flush_o(b_ex_mem_fl), .stall_cycles_o(b_stall),
    .flush_count_o(b_flush), .state_o(b_state));

  pipeline_hazard_controller #(.WB_BYPASS(1), .CTRL_POLICY(1), .CNT_WIDTH(32)) dut_c (
    .clk(clk), .reset(reset), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_is_ctrl_i(id_is_ctrl), .redirect_i(redirect),
    .pc_enable_o(c_pc_en), .if_id_enable_o(c_if_id_en), .if_id_flush_o(c_if_id_fl),
    .id_ex_flush_o(c_id_ex_fl), .ex_mem_flush_o(c_ex_mem_fl), .stall_cycles_o(c_stall),
    .flush_count_o(c_flush), .state_o(c_state));

  task automatic set_id(input logic v, input logic [4:0] rd, input logic rw,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic ctrl);
    id_valid = v; id_rd = rd; id_reg_write = rw;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2; id_is_ctrl = ctrl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    redirect = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    redirect = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    tests++;
    if (a_ctl !== NORMAL || a_state !== 1'b0 || a_stall !== 32'd0 || a_flush !== 32'd0) begin
      fails++;
      $display("FAIL reset: ctl=%b state=%b stall=%0d flush=%0d, want ctl=%b state=0 stall=0 flush=0",
               a_ctl, a_state, a_stall, a_flush, NORMAL);
    end
    tests++;
    if (c_ctl !== NORMAL || c_state !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl_inst: ctl=%b state=%b, want ctl=%b state=0", c_ctl, c_state, NORMAL);
    end
    #1 reset = 1'b0;
    $display("[TB] reset: ctl=%b state=%b", a_ctl, a_state);
  endtask

  // addi x5 followed by a reader of x5, held in ID until it issues.
  task automatic test_load_use();
    logic [4:0] exp_ctl [4] = '{NORMAL, STALL, STALL, NORMAL};
    do_reset();
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 0) set_id(1, 5'd5, 1, 5'd1, 1, 5'd0, 0, 0);
      else          set_id(1, 5'd6, 1, 5'd5, 1, 5'd2, 1, 0);
      #1;
      tests++;
      if (a_ctl !== exp_ctl[cyc]) begin
        fails++;
        $display("FAIL load_use cyc%0d: ctl=%b, want %b", cyc, a_ctl, exp_ctl[cyc]);
      end
      $display("[TB] load_use cyc%0d ctl=%b", cyc, a_ctl);
    end
    tests++;
    if (a_stall !== 32'd2) begin
      fails++;
      $display("FAIL load_use_stall_count: got %0d, want 2", a_stall);
    end
  endtask

  task automatic test_wb_no_bypass();
    logic [4:0] exp_ctl [5] = '{NORMAL, STALL, STALL, STALL, NORMAL};
    do_reset();
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (cyc == 0) set_id(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0);
      else          set_id(1, 5'd0, 0, 5'd3, 1, 5'd5, 1, 0);
      #1;
      tests++;
      if (b_ctl !== exp_ctl[cyc]) begin
        fails++;
        $display("FAIL wb_no_bypass cyc%0d: ctl=%b, want %b", cyc, b_ctl, exp_ctl[cyc]);
      end
      $display("[TB] wb_no_bypass cyc%0d ctl=%b", cyc, b_ctl);
    end
    tests++;
    if (b_stall !== 32'd3) begin
      fails++;
      $display("FAIL wb_no_bypass_stall_count: got %0d, want 3", b_stall);
    end
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk);
    set_id(1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clk);
    set_id(1, 5'd4, 1, 5'd0, 1, 5'd0, 1, 0);
    #1;
    tests++;
    if (a_ctl !== NORMAL || b_ctl !== NORMAL) begin
      fails++;
      $display("FAIL x0_no_stall: a=%b b=%b, want %b", a_ctl, b_ctl, NORMAL);
    end
    $display("[TB] x0 a=%b b=%b", a_ctl, b_ctl);
  endtask

  // rs2 hit in MEM stalls one cycle; an unused rs2 never stalls.
  task automatic test_back_to_back();
    logic [4:0] exp_ctl [4] = '{NORMAL, NORMAL, STALL, NORMAL};
    do_reset();
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      case (cyc)
        0:       set_id(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0);
        1:       set_id(1, 5'd3, 1, 5'd9, 0, 5'd9, 0, 0);
        default: set_id(1, 5'd0, 0, 5'd1, 1, 5'd9, 1, 0);
      endcase
      #1;
      tests++;
      if (a_ctl !== exp_ctl[cyc]) begin
        fails++;
        $display("FAIL back_to_back cyc%0d: ctl=%b, want %b", cyc, a_ctl, exp_ctl[cyc]);
      end
      $display("[TB] back_to_back cyc%0d ctl=%b", cyc, a_ctl);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    @(negedge clk);
    set_id(1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clk);
    set_id(1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0);
    redirect = 1'b1;
    #1;
    tests++;
    if (a_ctl !== REDIR) begin
      fails++;
      $display("FAIL redirect_over_hazard: ctl=%b, want %b", a_ctl, REDIR);
    end
    $display("[TB] redirect ctl=%b", a_ctl);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    tests++;
    if (a_ctl !== NORMAL || a_flush !== 32'd1 || a_stall !== 32'd0) begin
      fails++;
      $display("FAIL redirect_after: ctl=%b flush=%0d stall=%0d, want ctl=%b flush=1 stall=0",
               a_ctl, a_flush, a_stall, NORMAL);
    end
    $display("[TB] redirect_after ctl=%b flush=%0d", a_ctl, a_flush);
  endtask

  task automatic test_ctrl_wait(input logic redir);
    logic [4:0] exp_ctl   [5];
    logic       exp_state [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_ctl = '{HOLD, HOLD, HOLD, redir ? REDIR : NORMAL, NORMAL};
    do_reset();
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (cyc == 0) set_id(1, 5'd0, 0, 5'd1, 1, 5'd2, 1, 1);
      else          set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
      redirect = (cyc == 3) ? redir : 1'b0;
      #1;
      tests++;
      if (c_ctl !== exp_ctl[cyc] || c_state !== exp_state[cyc]) begin
        fails++;
        $display("FAIL ctrl_wait redir=%0b cyc%0d: ctl=%b state=%b, want ctl=%b state=%b",
                 redir, cyc, c_ctl, c_state, exp_ctl[cyc], exp_state[cyc]);
      end
      $display("[TB] ctrl_wait redir=%0b cyc%0d ctl=%b state=%b", redir, cyc, c_ctl, c_state);
    end
    tests++;
    if (c_stall !== 32'd3 || c_flush !== (redir ? 32'd1 : 32'd0)) begin
      fails++;
      $display("FAIL ctrl_wait_counters redir=%0b: stall=%0d flush=%0d, want stall=3 flush=%0d",
               redir, c_stall, c_flush, redir);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    set_id(1, 5'd0, 0, 5'd1, 0, 5'd2, 0, 1);
    @(negedge clk);
    set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    #1;
    tests++;
    if (c_state !== 1'b1 || c_ctl !== HOLD || c_stall !== 32'd1) begin
      fails++;
      $display("FAIL async_reset_pre: state=%b ctl=%b stall=%0d, want state=1 ctl=%b stall=1",
               c_state, c_ctl, c_stall, HOLD);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (c_state !== 1'b0 || c_ctl !== NORMAL || c_stall !== 32'd0 || c_flush !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: state=%b ctl=%b stall=%0d flush=%0d, want state=0 ctl=%b counters 0",
               c_state, c_ctl, c_stall, c_flush, NORMAL);
    end
    $display("[TB] async_reset state=%b ctl=%b stall=%0d", c_state, c_ctl, c_stall);
    #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_wb_no_bypass();
    test_x0();
    test_back_to_back();
    test_redirect();
    test_ctrl_wait(1'b0);
    test_ctrl_wait(1'b1);
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
